// File: rtl/fir_serial_mac_ctrl_if.sv
// Bundle of sample, coefficient, multiplier and result signals for the serial FIR sequencer.
// The slave side is the sequencer; the master side is the surrounding datapath/bench.
interface fir_serial_mac_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] filter_in;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_ready;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_p;
  logic        busy;
  logic [2:0]  tap_idx;
  logic        out_valid;
  logic [32:0] filter_out;

  modport master (
    output in_valid, filter_in, cfg_we, cfg_addr, cfg_data, mul_p,
    input  in_ready, cfg_ready, mul_a, mul_b, busy, tap_idx, out_valid, filter_out
  );

  modport slave (
    input  in_valid, filter_in, cfg_we, cfg_addr, cfg_data, mul_p,
    output in_ready, cfg_ready, mul_a, mul_b, busy, tap_idx, out_valid, filter_out
  );
endinterface

// File: rtl/fir_serial_mac_ctrl.sv
// 8-tap fully-serial FIR sequencer: one external multiply per tap, accumulate, strobe result.
// Delay line and coefficient bank only change while the controller is idle.
module fir_serial_mac_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  fir_serial_mac_ctrl_if.slave  bus
);
  localparam int NTAPS = 8;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  // Default coefficient k lives at bits [16k +: 16]
  localparam logic [NTAPS*16-1:0] COEF_INIT = {
    16'hDDBB, 16'hEA8E, 16'h33DB, 16'h6808,
    16'h6808, 16'h33DB, 16'hEA8E, 16'hDDBB
  };

  logic [0:0]  state_reg;
  logic [2:0]  tap_reg;
  logic [32:0] acc_reg;
  logic [32:0] filter_out_reg;
  logic        out_valid_reg;
  logic [15:0] d_reg     [NTAPS];
  logic [15:0] d_next    [NTAPS];
  logic [15:0] coef_reg  [NTAPS];
  logic [15:0] coef_next [NTAPS];

  logic        idle;
  logic        accept;
  logic        cfg_commit;
  logic [32:0] p_ext;
  logic [32:0] acc_sum;
  logic        unused_p_msb;

  assign idle       = (state_reg == ST_IDLE);
  assign accept     = clk_enable & bus.in_valid & idle;
  assign cfg_commit = clk_enable & bus.cfg_we & idle;

  // Product bit 31 only differs from bit 30 for (-1)*(-1); it is dropped.
  assign p_ext        = {{2{bus.mul_p[30]}}, bus.mul_p[30:0]};
  assign unused_p_msb = bus.mul_p[31];
  assign acc_sum      = (tap_reg == 3'd0) ? p_ext : acc_reg + p_ext;

  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign d_next[gi] = accept ? bus.filter_in : d_reg[gi];
      end else begin : g_body
        assign d_next[gi] = accept ? d_reg[gi-1] : d_reg[gi];
      end
      assign coef_next[gi] = (cfg_commit && (bus.cfg_addr == 3'(gi))) ? bus.cfg_data
                                                                        : coef_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        d_reg[k]    <= '0;
        coef_reg[k] <= COEF_INIT[k*16 +: 16];
      end
    end else begin
      d_reg    <= d_next;
      coef_reg <= coef_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      tap_reg        <= '0;
      acc_reg        <= '0;
      filter_out_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else if (clk_enable) begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_reg <= ST_RUN;
            tap_reg   <= '0;
          end
        end
        default: begin
          acc_reg <= acc_sum;
          if (tap_reg == 3'(NTAPS - 1)) begin
            filter_out_reg <= acc_sum;
            out_valid_reg  <= 1'b1;
            state_reg      <= ST_IDLE;
            tap_reg        <= '0;
          end else begin
            tap_reg <= tap_reg + 3'd1;
          end
        end
      endcase
    end
  end

  // tap_reg is 0 in IDLE, so the operands idle on d[0]/coef[0]
  assign bus.mul_a      = d_reg[tap_reg];
  assign bus.mul_b      = coef_reg[tap_reg];
  assign bus.in_ready   = idle;
  assign bus.cfg_ready  = idle;
  assign bus.busy       = ~idle;
  assign bus.tap_idx    = tap_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.filter_out = filter_out_reg;
endmodule

// File: tb/tb_fir_serial_mac_ctrl.sv
// Scoreboard bench for fir_serial_mac_ctrl with a behavioural combinational multiplier.
// Driver pushes hand-computed results and arrival cycles; the monitor pops on out_valid.
module tb_fir_serial_mac_ctrl;
  logic clk;
  logic reset;
  logic clk_enable;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    logic signed [32:0] val;
    int                 cyc;
    string              name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  fir_serial_mac_ctrl_if bus ();

  fir_serial_mac_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  assign bus.mul_p = $signed({{16{bus.mul_a[15]}}, bus.mul_a})
                   * $signed({{16{bus.mul_b[15]}}, bus.mul_b});

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every out_valid seen at a negedge must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.out_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL spurious_out_valid got=%0d required=no_output cyc=%0d",
                 $signed(bus.filter_out), cyc);
      end else begin
        mon_e = q.pop_front();
        if ($signed(bus.filter_out) !== mon_e.val) begin
          failures++;
          $display("FAIL %s value got=%0d required=%0d", mon_e.name,
                   $signed(bus.filter_out), mon_e.val);
        end
        checks++;
        if (cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL %s latency got_cyc=%0d required_cyc=%0d", mon_e.name, cyc, mon_e.cyc);
        end
        $display("txn %s out=%0d exp=%0d cyc=%0d", mon_e.name, $signed(bus.filter_out),
                 mon_e.val, cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] x, input logic signed [32:0] expv, input int extra,
                      input bit push, input string name, output int acc_cyc);
    int   n;
    exp_t e;
    bus.filter_in = x;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept"}, 64'(bus.in_ready), 64'd1);
    acc_cyc = cyc + 1;
    if (push) begin
      e.val  = expv;
      e.cyc  = cyc + 9 + extra;
      e.name = name;
      q.push_back(e);
    end
    $display("send %s in=%h accept_cyc=%0d", name, x, acc_cyc);
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic wait_tap(input logic [2:0] t, input string name);
    int n;
    n = 0;
    while (!(bus.busy && bus.tap_idx == t) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reach_tap"}, 64'(bus.tap_idx), 64'(t));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  logic signed [32:0] imp_exp [8];
  logic signed [32:0] dc_exp  [8];
  logic [15:0]        imp_in  [8];

  initial begin
    int ac;
    int prev_ac;
    imp_exp = '{-33'sd143736832, -33'sd89948160, 33'sd217497600, 33'sd436338688,
                33'sd436338688, 33'sd217497600, -33'sd89948160, -33'sd143736832};
    dc_exp  = '{-33'sd287464891, -33'sd467355721, -33'sd32373796, 33'sd840276948,
                33'sd1712927692, 33'sd2147909617, 33'sd1968018787, 33'sd1680553896};
    imp_in  = '{16'h4000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
    cyc = 0; checks = 0; failures = 0;
    reset = 1'b1; clk_enable = 1'b1;
    bus.in_valid = 1'b0; bus.filter_in = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      chk("idle_filter_out", 64'(bus.filter_out), 64'd0);
      chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
      chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
      chk("idle_cfg_ready", 64'(bus.cfg_ready), 64'd1);
      chk("idle_busy", 64'(bus.busy), 64'd0);
      chk("idle_tap_idx", 64'(bus.tap_idx), 64'd0);
      chk("idle_mul_a", 64'(bus.mul_a), 64'h0);
      chk("idle_mul_b", 64'(bus.mul_b), 64'hDDBB);
      chk("idle_mul_p", 64'(bus.mul_p), 64'h0);
      @(negedge clk);
    end

    // Impulse response
    for (int i = 0; i < 8; i++) send(imp_in[i], imp_exp[i], 0, 1'b1, $sformatf("impulse%0d", i), ac);
    bus.in_valid = 1'b0;
    drain("impulse");

    // DC with in_valid held high: accepts must be 9 cycles apart
    prev_ac = 0;
    for (int i = 0; i < 8; i++) begin
      send(16'h7FFF, dc_exp[i], 0, 1'b1, $sformatf("dc%0d", i), ac);
      if (i > 0) chk($sformatf("dc%0d_accept_spacing", i), 64'(ac - prev_ac), 64'd9);
      prev_ac = ac;
    end
    bus.in_valid = 1'b0;
    drain("dc");

    // Reset while idle clears the held result
    reset = 1'b1;
    #1;
    chk("rst_filter_out", 64'(bus.filter_out), 64'd0);
    chk("rst_mul_b", 64'(bus.mul_b), 64'hDDBB);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Stall 5 cycles at tap 3
    send(16'h4000, -33'sd143736832, 5, 1'b1, "stall_impulse", ac);
    bus.in_valid = 1'b0;
    wait_tap(3'd3, "stall");
    clk_enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_tap_hold", 64'(bus.tap_idx), 64'd3);
    clk_enable = 1'b1;
    drain("stall");

    // Coefficient writes
    pulse_reset();
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 16'h4000;
    chk("cfg_ready_idle", 64'(bus.cfg_ready), 64'd1);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    send(16'h7FFF, 33'sd536854528, 0, 1'b1, "coef_w0_impulse", ac);
    bus.in_valid = 1'b0;
    drain("coef_w0");
    send(16'h4000, 33'sd88544626, 0, 1'b1, "held_cfg_run", ac);
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_data = 16'h2000;
    chk("cfg_ready_run", 64'(bus.cfg_ready), 64'd0);
    for (int n = 0; n < 30 && !bus.cfg_ready; n++) @(negedge clk);
    send(16'h0000, 33'sd569199653, 0, 1'b1, "cfg_and_accept", ac);
    bus.cfg_we = 1'b0;
    bus.in_valid = 1'b0;
    drain("cfg_held");

    // Reset at tap 4 abandons the partial sum
    send(16'h7FFF, 33'sd0, 0, 1'b0, "aborted", ac);
    bus.in_valid = 1'b0;
    wait_tap(3'd4, "abort");
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_tap_idx", 64'(bus.tap_idx), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_filter_out", 64'(bus.filter_out), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_coef_revert", 64'(bus.mul_b), 64'hDDBB);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    send(16'h4000, -33'sd143736832, 0, 1'b1, "post_reset_impulse", ac);
    bus.in_valid = 1'b0;
    drain("post_reset");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_serial_mac_ctrl.md
# fir_serial_mac_ctrl

Sequencer for the 8-tap fully-serial FIR datapath. It accepts input samples on a valid/ready handshake and keeps the 8-deep sample delay line and a writable 8-entry coefficient bank. For each sample it drives the shared external 16x16 multiplier once per tap, accumulates the products and presents the filtered result with a valid strobe. It replaces the free-running phase counter, so the multiplier and adder only toggle when a sample is pending.

## Interface
- NTAPS, 8, number of taps; fixed at 8 (tap index is 3 bits).
- clk  in  1  system clock; all registers on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clk_enable  in  1  global advance; when low every register holds.
- in_valid  in  1  filter_in carries a sample.
- in_ready  out  1  controller can accept a sample; high only in IDLE.
- filter_in  in  16  sample, sfix16_En15.
- cfg_we  in  1  coefficient write request.
- cfg_addr  in  3  coefficient index 0..7.
- cfg_data  in  16  coefficient, sfix16_En16.
- cfg_ready  out  1  write accepted this cycle; equals in_ready.
- mul_a  out  16  multiplier operand: the selected delay-line sample.
- mul_b  out  16  multiplier operand: the selected coefficient.
- mul_p  in  32  combinational product of mul_a*mul_b from the external multiplier, sfix32_En31.
- busy  out  1  high in RUN.
- tap_idx  out  3  current tap in RUN; 0 otherwise.
- out_valid  out  1  registered strobe; filter_out is new.
- filter_out  out  33  result, sfix33_En31, held until the next result.

## Operation
- States: IDLE and RUN.
- IDLE -> RUN on an enabled edge with in_valid=1.
  - On that edge the delay line shifts: d[0]<=filter_in, d[k]<=d[k-1].
  - tap_idx<=0 and acc is not touched.
- RUN computes one tap per enabled cycle:
  - mul_a=d[tap_idx] and mul_b=coef[tap_idx].
  - p = sign-extend mul_p[30:0] to 33 bits; bit 31 of mul_p is discarded.
  - Accumulate: acc<=p when tap_idx=0, else acc<=acc+p.
  - Accumulation is modulo 2^33 with no saturation.
- Last tap (tap_idx=7):
  - filter_out<=acc+p and out_valid<=1.
  - State returns to IDLE and tap_idx<=0.
- out_valid clears on the next enabled edge, so it is high for exactly one enabled cycle.
- In IDLE, mul_a=d[0] and mul_b=coef[0]; the product is unused.
- Coefficient writes:
  - Committed on an enabled edge with cfg_we=1 in IDLE.
  - cfg_we while in RUN is ignored (cfg_ready=0); the requester must hold it.
  - A write and a sample accept in the same edge are both committed. The following RUN uses the new coefficient.
- Coefficient reset values, coef[0..7]: 0xDDBB, 0xEA8E, 0x33DB, 0x6808, 0x6808, 0x33DB, 0xEA8E, 0xDDBB.
- in_valid during RUN is not accepted; the sample must be held until in_ready.

## Timing
- Reset values:
  - State IDLE, in_ready=1, cfg_ready=1, busy=0, tap_idx=0.
  - out_valid=0, filter_out=0, acc=0, all d[k]=0, coef at the defaults above.
- Latency: sample accepted at edge E0 gives out_valid=1 after edge E8 (8 enabled cycles).
- Throughput: one sample per 9 enabled cycles (accept cycle plus 8 taps).
- clk_enable=0: state, tap_idx, acc, the delay line, coef, out_valid and filter_out all hold. A stall mid-RUN resumes on the same tap.
- Asynchronous reset mid-RUN: the partial sum is abandoned and no out_valid is issued. Coefficients revert to the defaults.
- mul_p must settle within one cycle of a mul_a/mul_b change; the controller has no multiplier pipeline stage.

## Test plan
- Reset then idle: filter_out=0, out_valid=0, in_ready=1, and mul_a/mul_b/mul_p stay constant.
- Impulse 0x4000 then seven 0x0000 samples:
  - Outputs in order: -143736832, -89948160, 217497600, 436338688, 436338688, 217497600, -89948160, -143736832.
  - Each output arrives 8 enabled cycles after its accept.
- DC: eight consecutive 0x7FFF samples. The eighth output is 1680553896, and out_valid pulses exactly once per sample.
- Coefficient write in IDLE: write coef[0]=0x4000, then inject impulse 0x7FFF. First output = 32767*16384 = 536854528.
  - A cfg_we held during RUN is not committed until in_ready returns.
- Backpressure and stall:
  - in_valid held high during RUN: the second sample is accepted only on the IDLE edge.
  - clk_enable low for 5 cycles at tap 3: identical result, delayed 5 cycles.
- Reset asserted at tap 4: outputs go to reset values immediately and no out_valid follows. The next impulse 0x4000 yields -143736832.
